ysyx_25020037_axi_arbiter: RTL and testbench
============================================

# ysyx_25020037_axi_arbiter

Two-master, one-slave AXI4 arbiter placed between the core's memory-side masters and the SoC bus. Master 0 is the IFU (read-only) and master 1 is the LSU (read and write). The arbiter grants exactly one transaction at a time and routes all five channels combinationally to the granted master. It holds the grant until the transaction's final response handshake completes.

## Interface
- No parameters. Widths are fixed: addr 32, data 32, id 4, len 8, size 3, burst 2, strb 4, resp 2.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ifu_arvalid/arready/araddr/arid/arlen/arsize/arburst  in/out/in/in/in/in/in  1/1/32/4/8/3/2  IFU read-address channel
- ifu_rvalid/rready/rdata/rresp/rlast/rid  out/in/out/out/out/out  1/1/32/2/1/4  IFU read-data channel
- lsu_arvalid/arready/araddr/arid/arlen/arsize/arburst  same directions and widths as IFU AR  LSU read-address channel
- lsu_rvalid/rready/rdata/rresp/rlast/rid  same as IFU R  LSU read-data channel
- lsu_awvalid/awready/awaddr/awid/awlen/awsize/awburst  in/out/in/in/in/in/in  1/1/32/4/8/3/2  LSU write-address channel
- lsu_wvalid/wready/wdata/wstrb/wlast  in/out/in/in/in  1/1/32/4/1  LSU write-data channel
- lsu_bvalid/bready/bresp/bid  out/in/out/out  1/1/2/4  LSU write-response channel
- out_aw*/w*/b*/ar*/r*  mirror of the LSU channels, with directions reversed toward the slave  SoC bus

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. State is registered; the encoding is free.
- Arbitration happens in IDLE only, with fixed priority:
  - lsu_arvalid → LSU_RD
  - else lsu_awvalid (with or without lsu_wvalid) → LSU_WR
  - else ifu_arvalid → IFU_RD
  - else stay in IDLE.
- The LSU has priority because it stalls the pipeline. The IFU cannot starve: the LSU issues at most one request per instruction, and each instruction needs a fetch.
- Routing:
  - IFU_RD: out_ar*/out_r* connect to ifu_*.
  - LSU_RD: out_ar*/out_r* connect to lsu_ar*/lsu_r*.
  - LSU_WR: out_aw*/out_w*/out_b* connect to lsu_*.
- Routing is pure pass-through. No field (id, len, size, burst, strb, resp) is modified.
- Ungranted paths:
  - Every out_*valid and out_rready/out_bready is 0.
  - Every master-side *ready and r/bvalid is 0.
  - Master-side rdata/rresp/rid/rlast/bresp/bid are 0.
  - out_* payload is 0.
- Completion:
  - IFU_RD/LSU_RD: on the cycle where out_rvalid & granted rready & out_rlast, return to IDLE.
  - LSU_WR: on the cycle where out_bvalid & lsu_bready, return to IDLE.
- Beats before rlast in a burst (len>0) keep the grant.
- Error responses (resp≠0) pass through and complete the transaction normally. The arbiter takes no error action.
- The AW and W channels pass independently. The arbiter neither requires nor forces a same-cycle AW/W handshake; the slave's ready timing is visible unchanged to the LSU.
- A master request that arrives while another master holds the grant waits, with its valid held per AXI rules, and sees ready=0 until granted.

## Timing
- Reset (asynchronous, any cycle including mid-burst): state = IDLE immediately. All outputs go to 0 within the reset cycle; all are combinational from state plus inputs.
- Grant latency: a request that is valid in IDLE at edge N gets state = grant after edge N. The slave sees out_*valid from cycle N+1. That is one bubble cycle per transaction.
- Address and data paths are combinational once granted: master valid to slave valid, and slave ready to master ready, with zero cycles added.
- Release: the last handshake occurs in cycle M, state = IDLE after edge M, and a new grant is possible after edge M+1. Back-to-back transactions are therefore spaced by at least one IDLE cycle.
- Simultaneous requests in IDLE: the priority rule decides. The losing master's valid stays asserted, and it is granted after the winner's release plus one IDLE cycle.
- A request withdrawn in IDLE before the grant edge is not an AXI-legal master behaviour. The arbiter still grants from the inputs sampled at the edge.

## Test plan
- IFU single read: ifu_arvalid with araddr=0x3000_0000, slave arready after 1 cycle, then rvalid with rdata=0xDEADBEEF, rlast=1. Required: ifu_rdata=0xDEADBEEF, ifu_rresp=0, and state back to IDLE the cycle after the handshake.
- LSU SB write: lsu_aw/w valid together with awaddr=0xA000_0002, wstrb=0b0100, wdata=0x00AB0000. Required: out_* carries identical values; lsu_bvalid is asserted in the same cycle as out_bvalid with bresp=0.
- Contention: ifu_arvalid and lsu_arvalid both asserted in IDLE. Required: LSU is granted first; ifu_arready stays 0 until the LSU's rlast handshake plus 2 cycles; the IFU is then served.
- Burst: IFU read with arlen=3 and arburst=INCR at 0xA000_0000. Required: 4 beats forwarded in order; the grant is held until beat 4 (rlast); an LSU request during the burst waits.
- Error passthrough: the slave returns rresp=2'b10 on an LSU read. Required: lsu_rresp=2'b10 and the transaction completes normally.
- Reset mid-transaction: assert rst during LSU_WR after the AW handshake. Required: all outputs are 0 immediately, state is IDLE after reset release, and a subsequent IFU read completes normally.

Source files
------------

// File: rtl/ysyx_25020037_axi_arbiter.sv
// rtl/ysyx_25020037_axi_arbiter.sv - two-master (IFU, LSU) to one-slave AXI4 arbiter
//
// Grants one whole transaction at a time with fixed priority
// (LSU read > LSU write > IFU read), and routes the granted master's
// channels combinationally to the slave port.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   ifu_ar*, ifu_r*     IFU read-address / read-data channels (read-only master)
//   lsu_ar*, lsu_r*     LSU read-address / read-data channels
//   lsu_aw*, lsu_w*,    LSU write-address / write-data / write-response channels
//   lsu_b*
//   out_*               slave-side mirror of the LSU channels toward the SoC bus
module ysyx_25020037_axi_arbiter (
   input  logic        clk,
   input  logic        rst,
   // IFU AR / R
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   input  logic [31:0] ifu_araddr,
   input  logic [3:0]  ifu_arid,
   input  logic [7:0]  ifu_arlen,
   input  logic [2:0]  ifu_arsize,
   input  logic [1:0]  ifu_arburst,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   output logic        ifu_rlast,
   output logic [3:0]  ifu_rid,
   // LSU AR / R
   input  logic        lsu_arvalid,
   output logic        lsu_arready,
   input  logic [31:0] lsu_araddr,
   input  logic [3:0]  lsu_arid,
   input  logic [7:0]  lsu_arlen,
   input  logic [2:0]  lsu_arsize,
   input  logic [1:0]  lsu_arburst,
   output logic        lsu_rvalid,
   input  logic        lsu_rready,
   output logic [31:0] lsu_rdata,
   output logic [1:0]  lsu_rresp,
   output logic        lsu_rlast,
   output logic [3:0]  lsu_rid,
   // LSU AW / W / B
   input  logic        lsu_awvalid,
   output logic        lsu_awready,
   input  logic [31:0] lsu_awaddr,
   input  logic [3:0]  lsu_awid,
   input  logic [7:0]  lsu_awlen,
   input  logic [2:0]  lsu_awsize,
   input  logic [1:0]  lsu_awburst,
   input  logic        lsu_wvalid,
   output logic        lsu_wready,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wstrb,
   input  logic        lsu_wlast,
   output logic        lsu_bvalid,
   input  logic        lsu_bready,
   output logic [1:0]  lsu_bresp,
   output logic [3:0]  lsu_bid,
   // slave side
   output logic        out_awvalid,
   input  logic        out_awready,
   output logic [31:0] out_awaddr,
   output logic [3:0]  out_awid,
   output logic [7:0]  out_awlen,
   output logic [2:0]  out_awsize,
   output logic [1:0]  out_awburst,
   output logic        out_wvalid,
   input  logic        out_wready,
   output logic [31:0] out_wdata,
   output logic [3:0]  out_wstrb,
   output logic        out_wlast,
   input  logic        out_bvalid,
   output logic        out_bready,
   input  logic [1:0]  out_bresp,
   input  logic [3:0]  out_bid,
   output logic        out_arvalid,
   input  logic        out_arready,
   output logic [31:0] out_araddr,
   output logic [3:0]  out_arid,
   output logic [7:0]  out_arlen,
   output logic [2:0]  out_arsize,
   output logic [1:0]  out_arburst,
   input  logic        out_rvalid,
   output logic        out_rready,
   input  logic [31:0] out_rdata,
   input  logic [1:0]  out_rresp,
   input  logic        out_rlast,
   input  logic [3:0]  out_rid
);

   typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

   state_t state, state_next;

   // Final handshake of the granted transaction; built from the master-side
   // ready of whichever master owns the grant.
   logic rd_done, wr_done;
   assign rd_done = out_rvalid & out_rlast &
                    (((state == IFU_RD) & ifu_rready) | ((state == LSU_RD) & lsu_rready));
   assign wr_done = (state == LSU_WR) & out_bvalid & lsu_bready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if      (lsu_arvalid) state_next = LSU_RD;
            else if (lsu_awvalid) state_next = LSU_WR;
            else if (ifu_arvalid) state_next = IFU_RD;
         end
         IFU_RD, LSU_RD: if (rd_done) state_next = IDLE;
         LSU_WR:         if (wr_done) state_next = IDLE;
         default:        state_next = IDLE;
      endcase
   end

   always_comb begin
      // everything not owned by the current grant is held at 0
      ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0; ifu_rresp = '0; ifu_rlast = 1'b0; ifu_rid = '0;
      lsu_arready = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0; lsu_rresp = '0; lsu_rlast = 1'b0; lsu_rid = '0;
      lsu_awready = 1'b0; lsu_wready = 1'b0; lsu_bvalid = 1'b0; lsu_bresp = '0; lsu_bid = '0;
      out_awvalid = 1'b0; out_awaddr = '0; out_awid = '0; out_awlen = '0; out_awsize = '0; out_awburst = '0;
      out_wvalid = 1'b0; out_wdata = '0; out_wstrb = '0; out_wlast = 1'b0; out_bready = 1'b0;
      out_arvalid = 1'b0; out_araddr = '0; out_arid = '0; out_arlen = '0; out_arsize = '0; out_arburst = '0;
      out_rready = 1'b0;
      case (state)
         IFU_RD: begin
            out_arvalid = ifu_arvalid; out_araddr = ifu_araddr; out_arid = ifu_arid;
            out_arlen = ifu_arlen; out_arsize = ifu_arsize; out_arburst = ifu_arburst;
            ifu_arready = out_arready;
            ifu_rvalid = out_rvalid; ifu_rdata = out_rdata; ifu_rresp = out_rresp;
            ifu_rlast = out_rlast; ifu_rid = out_rid;
            out_rready = ifu_rready;
         end
         LSU_RD: begin
            out_arvalid = lsu_arvalid; out_araddr = lsu_araddr; out_arid = lsu_arid;
            out_arlen = lsu_arlen; out_arsize = lsu_arsize; out_arburst = lsu_arburst;
            lsu_arready = out_arready;
            lsu_rvalid = out_rvalid; lsu_rdata = out_rdata; lsu_rresp = out_rresp;
            lsu_rlast = out_rlast; lsu_rid = out_rid;
            out_rready = lsu_rready;
         end
         LSU_WR: begin
            // AW and W pass independently; no pairing of their handshakes
            out_awvalid = lsu_awvalid; out_awaddr = lsu_awaddr; out_awid = lsu_awid;
            out_awlen = lsu_awlen; out_awsize = lsu_awsize; out_awburst = lsu_awburst;
            lsu_awready = out_awready;
            out_wvalid = lsu_wvalid; out_wdata = lsu_wdata; out_wstrb = lsu_wstrb; out_wlast = lsu_wlast;
            lsu_wready = out_wready;
            lsu_bvalid = out_bvalid; lsu_bresp = out_bresp; lsu_bid = out_bid;
            out_bready = lsu_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// tb/tb_ysyx_25020037_axi_arbiter.sv - directed self-checking bench for the AXI arbiter
module tb_ysyx_25020037_axi_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
   logic [31:0] ifu_araddr, ifu_rdata;
   logic [3:0]  ifu_arid, ifu_rid;
   logic [7:0]  ifu_arlen;
   logic [2:0]  ifu_arsize;
   logic [1:0]  ifu_arburst, ifu_rresp;
   logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
   logic [31:0] lsu_araddr, lsu_rdata;
   logic [3:0]  lsu_arid, lsu_rid;
   logic [7:0]  lsu_arlen;
   logic [2:0]  lsu_arsize;
   logic [1:0]  lsu_arburst, lsu_rresp;
   logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast, lsu_bvalid, lsu_bready;
   logic [31:0] lsu_awaddr, lsu_wdata;
   logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
   logic [7:0]  lsu_awlen;
   logic [2:0]  lsu_awsize;
   logic [1:0]  lsu_awburst, lsu_bresp;
   logic        out_awvalid, out_awready, out_wvalid, out_wready, out_wlast, out_bvalid, out_bready;
   logic [31:0] out_awaddr, out_wdata;
   logic [3:0]  out_awid, out_wstrb, out_bid;
   logic [7:0]  out_awlen;
   logic [2:0]  out_awsize;
   logic [1:0]  out_awburst, out_bresp;
   logic        out_arvalid, out_arready, out_rvalid, out_rready, out_rlast;
   logic [31:0] out_araddr, out_rdata;
   logic [3:0]  out_arid, out_rid;
   logic [7:0]  out_arlen;
   logic [2:0]  out_arsize;
   logic [1:0]  out_arburst, out_rresp;

   int errors = 0;
   int checks = 0;

   ysyx_25020037_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
      .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
      .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
      .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
      .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
      .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
      .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
      .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
      .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
      .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_wlast(lsu_wlast), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
      .lsu_bid(lsu_bid),
      .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr), .out_awid(out_awid),
      .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
      .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
      .out_wlast(out_wlast), .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp),
      .out_bid(out_bid),
      .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr), .out_arid(out_arid),
      .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
      .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
      .out_rlast(out_rlast), .out_rid(out_rid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance past the next rising edge; inputs change here, checks follow a settle delay
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_arburst = 0; ifu_rready = 0;
      lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0; lsu_rready = 0;
      lsu_awvalid = 0; lsu_awaddr = 0; lsu_awid = 0; lsu_awlen = 0; lsu_awsize = 0; lsu_awburst = 0;
      lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0; lsu_bready = 0;
      out_awready = 0; out_wready = 0; out_bvalid = 0; out_bresp = 0; out_bid = 0;
      out_arready = 0; out_rvalid = 0; out_rdata = 0; out_rresp = 0; out_rlast = 0; out_rid = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst = 1;
      // ---------------- reset state ----------------
      out_arready = 1; out_rvalid = 1; out_bvalid = 1; out_wready = 1;
      ifu_arvalid = 1; lsu_rready = 1; lsu_bready = 1;
      #13;
      check("rst_out_arvalid", out_arvalid, 0);
      check("rst_ifu_arready", ifu_arready, 0);
      check("rst_lsu_rvalid", lsu_rvalid, 0);
      check("rst_lsu_bvalid", lsu_bvalid, 0);
      check("rst_out_rready", out_rready, 0);
      tick();
      clear_inputs();
      rst = 0;

      // ---------------- IFU single read ----------------
      ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arid = 4'h1; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
      #1 check("ifu1_idle_arvalid", out_arvalid, 0);
      tick();
      #1 check("ifu1_out_arvalid", out_arvalid, 1);
      check("ifu1_out_araddr", out_araddr, 32'h3000_0000);
      check("ifu1_arready_wait", ifu_arready, 0);
      tick();
      out_arready = 1;
      #1 check("ifu1_arready", ifu_arready, 1);
      tick();
      ifu_arvalid = 0; out_arready = 0;
      out_rvalid = 1; out_rdata = 32'hDEAD_BEEF; out_rresp = 0; out_rlast = 1; out_rid = 4'h1; ifu_rready = 1;
      #1 check("ifu1_rvalid", ifu_rvalid, 1);
      check("ifu1_rdata", ifu_rdata, 32'hDEAD_BEEF);
      check("ifu1_rresp", ifu_rresp, 0);
      check("ifu1_rid", ifu_rid, 4'h1);
      check("ifu1_out_rready", out_rready, 1);
      tick();
      // back in IDLE: slave response no longer routed
      #1 check("ifu1_idle_rready", out_rready, 0);
      check("ifu1_idle_rvalid", ifu_rvalid, 0);
      clear_inputs();
      tick();

      // ---------------- LSU SB write ----------------
      lsu_awvalid = 1; lsu_awaddr = 32'hA000_0002; lsu_awid = 4'h2; lsu_awsize = 3'd0; lsu_awburst = 2'b01;
      lsu_wvalid = 1; lsu_wdata = 32'h00AB_0000; lsu_wstrb = 4'b0100; lsu_wlast = 1; lsu_bready = 1;
      #1 check("wr_idle_awvalid", out_awvalid, 0);
      tick();
      #1 check("wr_out_awvalid", out_awvalid, 1);
      check("wr_out_awaddr", out_awaddr, 32'hA000_0002);
      check("wr_out_awid", out_awid, 4'h2);
      check("wr_out_awburst", out_awburst, 2'b01);
      check("wr_out_wvalid", out_wvalid, 1);
      check("wr_out_wdata", out_wdata, 32'h00AB_0000);
      check("wr_out_wstrb", out_wstrb, 4'b0100);
      check("wr_out_wlast", out_wlast, 1);
      // slave accepts AW only; W ready stays low and is seen unchanged
      out_awready = 1;
      #1 check("wr_awready", lsu_awready, 1);
      check("wr_wready_low", lsu_wready, 0);
      tick();
      lsu_awvalid = 0; out_awready = 0; out_wready = 1;
      #1 check("wr_wready", lsu_wready, 1);
      check("wr_awvalid_drop", out_awvalid, 0);
      tick();
      lsu_wvalid = 0; out_wready = 0;
      out_bvalid = 1; out_bresp = 0; out_bid = 4'h2;
      #1 check("wr_bvalid", lsu_bvalid, 1);
      check("wr_bresp", lsu_bresp, 0);
      check("wr_bid", lsu_bid, 4'h2);
      check("wr_out_bready", out_bready, 1);
      tick();
      #1 check("wr_idle_bvalid", lsu_bvalid, 0);
      check("wr_idle_bready", out_bready, 0);
      clear_inputs();
      tick();

      // ---------------- contention + error passthrough ----------------
      ifu_arvalid = 1; ifu_araddr = 32'h3000_0010;
      lsu_arvalid = 1; lsu_araddr = 32'h8000_0000; lsu_arid = 4'h5;
      out_arready = 1;
      #1 check("cont_idle_ifu_arready", ifu_arready, 0);
      tick();
      #1 check("cont_lsu_first_addr", out_araddr, 32'h8000_0000);
      check("cont_lsu_arready", lsu_arready, 1);
      check("cont_ifu_arready_g", ifu_arready, 0);
      tick();
      lsu_arvalid = 0;
      out_rvalid = 1; out_rlast = 1; out_rresp = 2'b10; out_rdata = 32'h0BAD_0BAD; out_rid = 4'h5; lsu_rready = 1;
      #1 check("err_lsu_rresp", lsu_rresp, 2'b10);
      check("err_lsu_rvalid", lsu_rvalid, 1);
      check("err_lsu_rid", lsu_rid, 4'h5);
      check("cont_ifu_rvalid", ifu_rvalid, 0);
      check("cont_ifu_arready_r", ifu_arready, 0);
      tick();
      out_rvalid = 0; out_rlast = 0; out_rresp = 0; lsu_rready = 0;
      #1 check("cont_ifu_arready_idle", ifu_arready, 0);
      tick();
      #1 check("cont_ifu_granted", ifu_arready, 1);
      check("cont_ifu_addr", out_araddr, 32'h3000_0010);
      tick();
      ifu_arvalid = 0; out_arready = 0;
      out_rvalid = 1; out_rlast = 1; out_rdata = 32'h1234_5678; ifu_rready = 1;
      #1 check("cont_ifu_rdata", ifu_rdata, 32'h1234_5678);
      tick();
      clear_inputs();
      tick();

      // ---------------- IFU burst with waiting LSU ----------------
      ifu_arvalid = 1; ifu_araddr = 32'hA000_0000; ifu_arlen = 8'd3; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
      tick();
      out_arready = 1;
      #1 check("burst_arlen", out_arlen, 8'd3);
      check("burst_arburst", out_arburst, 2'b01);
      check("burst_arready", ifu_arready, 1);
      tick();
      ifu_arvalid = 0;
      lsu_arvalid = 1; lsu_araddr = 32'h8000_0004;
      ifu_rready = 1; lsu_rready = 1;
      for (int i = 0; i < 4; i++) begin
         out_rvalid = 1; out_rdata = 32'h0000_1000 + i; out_rlast = (i == 3);
         #1 check($sformatf("burst_rdata%0d", i), ifu_rdata, 32'h0000_1000 + i);
         check($sformatf("burst_rlast%0d", i), ifu_rlast, (i == 3) ? 1 : 0);
         check($sformatf("burst_lsu_wait%0d", i), lsu_arready, 0);
         check($sformatf("burst_lsu_rvalid%0d", i), lsu_rvalid, 0);
         tick();
      end
      out_rvalid = 0; out_rlast = 0;
      #1 check("burst_idle_lsu_arready", lsu_arready, 0);
      tick();
      #1 check("burst_lsu_granted", lsu_arready, 1);
      check("burst_lsu_addr", out_araddr, 32'h8000_0004);
      tick();
      lsu_arvalid = 0; out_arready = 0;
      out_rvalid = 1; out_rlast = 1; out_rdata = 32'hCAFE_F00D;
      #1 check("burst_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
      tick();
      clear_inputs();
      tick();

      // ---------------- reset during LSU write ----------------
      lsu_awvalid = 1; lsu_awaddr = 32'hA000_0010; lsu_wvalid = 1; lsu_wdata = 32'h5555_AAAA; lsu_wstrb = 4'hF;
      lsu_wlast = 1; lsu_bready = 1;
      tick();
      out_awready = 1;
      tick();
      lsu_awvalid = 0; out_awready = 0; out_wready = 1; out_bvalid = 1;
      #1 check("rstmid_wvalid_pre", out_wvalid, 1);
      rst = 1;
      #1 check("rstmid_wvalid", out_wvalid, 0);
      check("rstmid_wdata", out_wdata, 0);
      check("rstmid_wready", lsu_wready, 0);
      check("rstmid_bvalid", lsu_bvalid, 0);
      check("rstmid_bready", out_bready, 0);
      tick();
      clear_inputs();
      rst = 0;
      ifu_arvalid = 1; ifu_araddr = 32'h3000_0020;
      #1 check("rstmid_idle_arvalid", out_arvalid, 0);
      tick();
      out_arready = 1;
      #1 check("rstmid_ifu_arready", ifu_arready, 1);
      check("rstmid_ifu_addr", out_araddr, 32'h3000_0020);
      tick();
      ifu_arvalid = 0; out_arready = 0;
      out_rvalid = 1; out_rlast = 1; out_rdata = 32'h7777_0001; ifu_rready = 1;
      #1 check("rstmid_ifu_rdata", ifu_rdata, 32'h7777_0001);
      tick();
      #1 check("rstmid_done_rready", out_rready, 0);
      clear_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
